spi_buffer_ctrl: RTL and testbench
==================================

Name: spi_buffer_ctrl

Overview:
- Sequences a single-port, two-bank word buffer between an SPI slave byte interface and the NITTA processor side.
- Per SPI frame (cs_n low), packs received bytes into DATA_WIDTH words and writes them to the SPI bank; fetches the outgoing words from the same addresses and serialises them MSB-byte first.
- On a complete frame, swaps banks so NITTA sees fresh received data; NITTA accesses to the other bank are arbitrated into idle memory cycles.

Parameters:
DATA_WIDTH, 32, buffer word width; must be a multiple of SPI_DATA_WIDTH
SPI_DATA_WIDTH, 8, SPI byte width
BUF_SIZE, 10, words per frame and per bank
ADDR_WIDTH, $clog2(BUF_SIZE), word address width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
spi_cs_n  in  1  frame select, active low, already synchronous to clk
spi_ready  in  1  one-cycle pulse per completed SPI byte
spi_data_receive  in  SPI_DATA_WIDTH  byte received, valid with spi_ready
spi_data_send  out  SPI_DATA_WIDTH  byte to shift out next
mem_addr  out  ADDR_WIDTH+1  {bank bit, word address}
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe; mem_rdata valid next cycle
mem_wdata  out  DATA_WIDTH  write data
mem_rdata  in  DATA_WIDTH  read data
nitta_req  in  1  NITTA access request, held until ack
nitta_we  in  1  1 = write, 0 = read
nitta_addr  in  ADDR_WIDTH  NITTA word address
nitta_wdata  in  DATA_WIDTH  NITTA write data
nitta_rdata  out  DATA_WIDTH  NITTA read data, valid with ack on reads, held until next read ack
nitta_ack  out  1  one-cycle access completion
bank  out  1  bank currently owned by SPI; NITTA uses ~bank
frame_done  out  1  one-cycle pulse, good frame, bank swapped
frame_err  out  1  one-cycle pulse, bad frame, no swap

Behaviour:
- Reset: all outputs 0, bank=0, state IDLE; word_idx, byte_cnt, overrun cleared. Reset mid-frame abandons the frame with no pulse.
- BPW = DATA_WIDTH/SPI_DATA_WIDTH (4). SPI byte period must be >= 4 clk.
- States and transitions:
  - IDLE: cs_n falling -> FETCH, word_idx=0, byte_cnt=0, overrun=0.
  - FETCH: mem_re=1, addr={bank,word_idx} -> LOAD.
  - LOAD: tx_shift<=mem_rdata -> ACTIVE. spi_data_send is always tx_shift[DATA_WIDTH-1 -: SPI_DATA_WIDTH].
  - ACTIVE, on spi_ready: rx_shift<={rx_shift,byte}; tx_shift<<=SPI_DATA_WIDTH; byte_cnt++.
    - At byte BPW: byte_cnt=0 -> WRITE.
    - In WRITE: mem_we=1, addr={bank,word_idx}, wdata=rx_shift; word_idx++.
    - After WRITE: -> FETCH if word_idx<BUF_SIZE, else -> ACTIVE in overflow mode.
  - Overflow mode: further bytes are ignored, spi_data_send=0, overrun=1.
  - spi_ready in FETCH, LOAD or WRITE: byte lost, overrun=1.
- End of frame: cs_n high seen in FETCH, LOAD or ACTIVE; WRITE always completes first and its cs_n check moves to the next cycle. Then go to IDLE and evaluate:
  - word_idx==BUF_SIZE && byte_cnt==0 && !overrun -> frame_done, bank toggles the same cycle.
  - otherwise -> frame_err, bank unchanged; partial word discarded, not written.
- NITTA arbitration (SPI has priority):
  - Grant in cycle G only if: state not FETCH/WRITE, no NITTA access outstanding, and the controller is not about to enter FETCH/WRITE.
  - Grant drives mem_* with addr {~bank, nitta_addr}.
  - nitta_ack in G+1; on reads nitta_rdata<=mem_rdata in G+1.
  - Requester drops or re-presents req after ack; no grant in an ack cycle.
- A bank swap between grant and ack does not affect the granted access.
- word_idx wraps to 0 only at frame start.

Test Plan:
- Reset, then read bank1 via NITTA after preloading word3=0xDEADBEEF -> ack one cycle after grant, nitta_rdata=0xDEADBEEF, mem_addr={1,3}.
- Full frame of 40 bytes 0x00..0x27, bank0 pre-filled word0=0xA1B2C3D4:
  - bank0 word0 written 0x00010203, word9=0x24252627.
  - First bytes sent: A1,B2,C3,D4.
  - frame_done pulses, bank=1.
- Frame of 39 bytes then cs_n high -> frame_err, bank stays 0, word9 not written.
- 44-byte frame -> overflow, spi_data_send=0 for bytes 41-44, frame_err, bank unchanged.
- spi_ready asserted during WRITE cycle -> overrun, frame_err at cs_n rise even with 40 good bytes.
- nitta_req held continuously during frame -> grants never coincide with FETCH/WRITE cycles; every request acked; writes land in bank ~bank.

Source files
------------

// File: rtl/spi_buffer_ctrl.sv
// spi_buffer_ctrl: sequences a single-port two-bank word buffer between an
// SPI slave byte interface and the NITTA processor side.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   spi_cs_n             frame select (active low, synchronous to clk)
//   spi_ready            one-cycle pulse per received SPI byte
//   spi_data_receive     received byte, valid with spi_ready
//   spi_data_send        byte to shift out next
//   mem_addr/we/re       buffer port, address = {bank bit, word address}
//   mem_wdata/rdata      buffer data (rdata valid the cycle after re)
//   nitta_req/we/addr    NITTA request, held until nitta_ack
//   nitta_wdata/rdata    NITTA data; rdata valid with ack, then held
//   nitta_ack            one-cycle completion, one cycle after the grant
//   bank                 bank owned by SPI; NITTA uses ~bank
//   frame_done/err       one-cycle end-of-frame status pulses
module spi_buffer_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int BUF_SIZE       = 10,
    parameter int ADDR_WIDTH     = $clog2(BUF_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_cs_n,
    input  logic                      spi_ready,
    input  logic [SPI_DATA_WIDTH-1:0] spi_data_receive,
    output logic [SPI_DATA_WIDTH-1:0] spi_data_send,
    output logic [ADDR_WIDTH:0]       mem_addr,
    output logic                      mem_we,
    output logic                      mem_re,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    input  logic                      nitta_req,
    input  logic                      nitta_we,
    input  logic [ADDR_WIDTH-1:0]     nitta_addr,
    input  logic [DATA_WIDTH-1:0]     nitta_wdata,
    output logic [DATA_WIDTH-1:0]     nitta_rdata,
    output logic                      nitta_ack,
    output logic                      bank,
    output logic                      frame_done,
    output logic                      frame_err
);
    localparam int BPW = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int IW  = ADDR_WIDTH + 1;
    localparam logic [IW-1:0] LAST     = IW'(BUF_SIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(BPW - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, ACTIVE, WRITE
    } state_t;

    state_t                state, state_n;
    logic                  cs_q;
    logic [IW-1:0]         word_idx;
    logic [CW-1:0]         byte_cnt;
    logic                  overrun;
    logic                  ovf;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ack_rd;
    logic                  gnt;
    logic                  frame_end;
    logic                  frame_ok;
    logic                  drop;
    logic                  take;

    // Bytes arriving while the memory port is busy, or after the buffer is
    // full, are lost and poison the frame.
    assign drop = spi_ready &&
                  (state == FETCH || state == LOAD || state == WRITE ||
                   (state == ACTIVE && ovf));
    assign take = state == ACTIVE && !spi_cs_n && spi_ready && !ovf;

    // WRITE never ends a frame; its cs_n check slides into FETCH/ACTIVE.
    assign frame_end = spi_cs_n &&
                       (state == FETCH || state == LOAD || state == ACTIVE);
    assign frame_ok  = word_idx == LAST && byte_cnt == '0 &&
                       !overrun && !drop;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (cs_q && !spi_cs_n) state_n = FETCH;
            FETCH:   state_n = spi_cs_n ? IDLE : LOAD;
            LOAD:    state_n = spi_cs_n ? IDLE : ACTIVE;
            ACTIVE: begin
                if (spi_cs_n)
                    state_n = IDLE;
                else if (take && byte_cnt == CNT_LAST)
                    state_n = WRITE;
            end
            WRITE:   state_n = (word_idx + 1'b1 < LAST) ? FETCH : ACTIVE;
            default: state_n = IDLE;
        endcase
    end

    // NITTA only gets cycles the SPI side is neither using nor about to use.
    assign gnt = nitta_req && !nitta_ack &&
                 state != FETCH && state != WRITE &&
                 state_n != FETCH && state_n != WRITE;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = '0;
        if (state == FETCH) begin
            mem_re   = 1'b1;
            mem_addr = {bank, word_idx[ADDR_WIDTH-1:0]};
        end else if (state == WRITE) begin
            mem_we    = 1'b1;
            mem_addr  = {bank, word_idx[ADDR_WIDTH-1:0]};
            mem_wdata = rx_shift;
        end else if (gnt) begin
            mem_addr  = {~bank, nitta_addr};
            mem_we    = nitta_we;
            mem_re    = !nitta_we;
            mem_wdata = nitta_wdata;
        end
    end

    assign spi_data_send = ovf ? '0 :
                           tx_shift[DATA_WIDTH-1 -: SPI_DATA_WIDTH];
    assign nitta_rdata   = (nitta_ack && ack_rd) ? mem_rdata : rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cs_q       <= 1'b0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            overrun    <= 1'b0;
            ovf        <= 1'b0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rdata_q    <= '0;
            ack_rd     <= 1'b0;
            nitta_ack  <= 1'b0;
            bank       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cs_q       <= spi_cs_n;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            nitta_ack  <= gnt;
            ack_rd     <= gnt && !nitta_we;
            if (nitta_ack && ack_rd)
                rdata_q <= mem_rdata;
            if (drop)
                overrun <= 1'b1;
            if (frame_end) begin
                if (frame_ok) begin
                    frame_done <= 1'b1;
                    bank       <= ~bank;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (state_n == FETCH) begin
                        word_idx <= '0;
                        byte_cnt <= '0;
                        overrun  <= 1'b0;
                        ovf      <= 1'b0;
                        tx_shift <= '0;
                        rx_shift <= '0;
                    end
                end
                LOAD: begin
                    if (!spi_cs_n)
                        tx_shift <= mem_rdata;
                end
                ACTIVE: begin
                    if (take) begin
                        rx_shift <= (rx_shift << SPI_DATA_WIDTH) |
                                    DATA_WIDTH'(spi_data_receive);
                        tx_shift <= tx_shift << SPI_DATA_WIDTH;
                        byte_cnt <= (byte_cnt == CNT_LAST) ? '0 :
                                    byte_cnt + 1'b1;
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    if (word_idx + 1'b1 >= LAST)
                        ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_buffer_ctrl.sv
// tb_spi_buffer_ctrl: randomized self-checking bench for spi_buffer_ctrl.
// Frame-level reference model: byte lists, word packing and bank ownership.
module tb_spi_buffer_ctrl;
    localparam int BS = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_cs_n, spi_ready;
    logic [7:0]  spi_data_receive, spi_data_send;
    logic [4:0]  mem_addr;
    logic        mem_we, mem_re;
    logic [31:0] mem_wdata, mem_rdata;
    logic        nitta_req, nitta_we;
    logic [3:0]  nitta_addr;
    logic [31:0] nitta_wdata, nitta_rdata;
    logic        nitta_ack, bank, frame_done, frame_err;

    always #5 clk = ~clk;

    spi_buffer_ctrl dut (
        .clk(clk), .rst(rst),
        .spi_cs_n(spi_cs_n), .spi_ready(spi_ready),
        .spi_data_receive(spi_data_receive),
        .spi_data_send(spi_data_send),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .nitta_req(nitta_req), .nitta_we(nitta_we),
        .nitta_addr(nitta_addr), .nitta_wdata(nitta_wdata),
        .nitta_rdata(nitta_rdata), .nitta_ack(nitta_ack),
        .bank(bank), .frame_done(frame_done), .frame_err(frame_err)
    );

    // Environment RAM with a bench-side preload port.
    logic [31:0] ram [0:31];
    logic        pl_we = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Reference model state.
    logic [31:0] exp_mem [0:31];
    logic        exp_bank;
    logic [7:0]  fb [$];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, got, want);
        end
    endtask

    // NITTA requester process.
    logic        nit_en = 1'b0;
    logic        nit_busy = 1'b0;
    int          one_req = 0;
    int          one_done = 0;
    logic        fix_we;
    logic [3:0]  fix_a;
    logic [31:0] fix_d;

    task automatic nit_op(input logic we, input logic [3:0] a,
                          input logic [31:0] d);
        bit ok = 0;
        int idx;
        nitta_req = 1'b1; nitta_we = we;
        nitta_addr = a;   nitta_wdata = d;
        idx = (exp_bank ? 0 : 16) + int'(a);
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if ((mem_re || mem_we) && mem_addr[4] !== bank) begin
                chk("nit_addr", mem_addr, 32'(idx));
                chk("nit_we", mem_we, we);
                chk("nit_ack_gnt", nitta_ack, 0);
                @(negedge clk);
                chk("nit_ack", nitta_ack, 1);
                if (!we) chk("nit_rdata", nitta_rdata, exp_mem[idx]);
                else exp_mem[idx] = d;
                ok = 1;
            end
        end
        if (!ok) chk("nit_timeout", 0, 1);
    endtask

    initial begin
        nitta_req = 1'b0; nitta_we = 1'b0;
        nitta_addr = '0;  nitta_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (nit_en) begin
                nit_busy = 1'b1;
                nit_op(1'($urandom_range(0, 1)),
                       4'($urandom_range(0, BS - 1)), $urandom);
                nit_busy = 1'b0;
            end else if (one_req != one_done) begin
                nit_op(fix_we, fix_a, fix_d);
                one_done++;
            end else begin
                nitta_req = 1'b0;
            end
        end
    end

    task automatic preload(input int a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_we = 1'b1; pl_addr = 5'(a); pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
        exp_mem[a] = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_bank", bank, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_mem", {mem_we, mem_re, mem_addr}, 0);
        chk("rst_ack", nitta_ack, 0);
        chk("rst_send", spi_data_send, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_bank = 1'b0;
    endtask

    // Drives one frame of fb[0..n-1]; lost_w >= 0 adds an extra spi_ready
    // in the WRITE cycle that follows word lost_w.
    task automatic run_frame(input int n, input int lost_w,
                             input bit with_nit);
        logic [7:0]  sent [$];
        logic [31:0] w;
        int          b, acc, nw, done_n, err_n;
        bit          hit, good, nb, ok;
        b = exp_bank ? 16 : 0;
        for (int i = 0; i < n; i++) begin
            w = exp_mem[b + i / 4];
            sent.push_back(i < 40 ? w[31 - 8 * (i % 4) -: 8] : 8'h00);
        end
        hit  = lost_w >= 0 && lost_w * 4 + 3 < n;
        good = n == 40 && !hit;
        nb   = good ? ~exp_bank : exp_bank;

        nit_en = with_nit;
        @(posedge clk); #1;
        spi_cs_n = 1'b0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            spi_ready = 1'b1;
            spi_data_receive = fb[i];
            @(negedge clk);
            chk($sformatf("tx_byte%0d", i), spi_data_send, sent[i]);
            @(posedge clk); #1;
            if (hit && i == lost_w * 4 + 3) begin
                @(posedge clk); #1;
            end
            spi_ready = 1'b0;
            repeat (2) @(posedge clk);
        end

        nit_en = 1'b0;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk); #2;
            ok = !nit_busy;
        end
        if (!ok) chk("nit_stop_timeout", 0, 1);

        @(posedge clk); #1;
        spi_cs_n = 1'b1;
        done_n = 0; err_n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (frame_done) begin
                done_n++;
                chk("bank_at_done", bank, nb);
            end
            if (frame_err) err_n++;
        end
        chk("done_cnt", done_n, 32'(good));
        chk("err_cnt", err_n, 32'(!good));

        acc = n < 40 ? n : 40;
        nw = acc / 4;
        for (int k = 0; k < nw; k++)
            exp_mem[b + k] = {fb[4*k], fb[4*k+1], fb[4*k+2], fb[4*k+3]};
        exp_bank = nb;
        chk("bank", bank, exp_bank);
        for (int k = 0; k < BS; k++) begin
            chk($sformatf("mem0_%0d", k), ram[k], exp_mem[k]);
            chk($sformatf("mem1_%0d", k), ram[16 + k], exp_mem[16 + k]);
        end
    endtask

    task automatic rand_bytes(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, lw;
        bit ok;
        rst = 1'b1;
        spi_cs_n = 1'b1; spi_ready = 1'b0; spi_data_receive = '0;
        exp_bank = 1'b0;
        do_reset();
        for (int a = 0; a < 32; a++) preload(a, $urandom);

        // NITTA read of bank 1 word 3.
        preload(5'h13, 32'hDEADBEEF);
        fix_we = 1'b0; fix_a = 4'd3; fix_d = '0;
        one_req++;
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(posedge clk); #2;
            ok = one_done == one_req;
        end
        if (!ok) chk("one_timeout", 0, 1);
        chk("nit_dead", nitta_rdata, 32'hDEADBEEF);

        // Full 40-byte frame, counting pattern.
        preload(0, 32'hA1B2C3D4);
        fb.delete();
        for (int i = 0; i < 40; i++) fb.push_back(8'(i));
        run_frame(40, -1, 0);
        chk("word0", ram[0], 32'h00010203);
        chk("word9", ram[9], 32'h24252627);
        chk("bank_full", bank, 1);

        // Short frame.
        do_reset();
        rand_bytes(39);
        run_frame(39, -1, 0);

        // Overlong frame.
        do_reset();
        rand_bytes(44);
        run_frame(44, -1, 0);

        // Byte lost in a WRITE cycle.
        do_reset();
        rand_bytes(40);
        run_frame(40, 2, 0);

        // Full frame with continuous NITTA traffic.
        do_reset();
        rand_bytes(40);
        run_frame(40, -1, 1);

        // Random frames, bank state carried across frames.
        for (int r = 0; r < 8; r++) begin
            n  = ($urandom_range(0, 1) == 1) ? 40 : $urandom_range(36, 44);
            lw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
            rand_bytes(n);
            run_frame(n, lw, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
